// File: rtl/warp_mem_arbiter_if.sv
// ============================================================================
// Module   : warp_mem_arbiter_if
// Brief    : Requester-side and memory-side bus bundle for warp_mem_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface warp_mem_arbiter_if #(
    parameter int NUM_REQ    = 9,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [DATA_WIDTH-1:0]         resp_data;
    logic                          mem_req_valid;
    logic                          mem_req_ready;
    logic [ADDR_WIDTH-1:0]         mem_req_addr;
    logic                          mem_req_write;
    logic [DATA_WIDTH-1:0]         mem_req_data;
    logic                          mem_resp_valid;
    logic                          mem_resp_ready;
    logic [DATA_WIDTH-1:0]         mem_resp_data;

    // The arbiter itself.
    modport slave (
        input  req_valid, req_addr, req_write, req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output req_ready, resp_valid, resp_data,
        output mem_req_valid, mem_req_addr, mem_req_write, mem_req_data,
        output mem_resp_ready
    );

    // The surrounding requesters and memory.
    modport master (
        output req_valid, req_addr, req_write, req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  req_ready, resp_valid, resp_data,
        input  mem_req_valid, mem_req_addr, mem_req_write, mem_req_data,
        input  mem_resp_ready
    );
endinterface

`default_nettype wire

// File: rtl/warp_mem_arbiter.sv
// ============================================================================
// Module   : warp_mem_arbiter
// Brief    : Round-robin (optional fetch-priority) arbiter sharing one memory
//            port between fetch and lane requesters, one transaction in flight.
// Revision : 1.0
// ============================================================================
`default_nettype none

module warp_mem_arbiter #(
    parameter int NUM_REQ        = 9,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int FETCH_PRIORITY = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    warp_mem_arbiter_if.slave               bus,
    input  wire logic                       clr_err,
    output logic                            busy,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            err_timeout
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W:0]   C_NUM_REQ  = (IDX_W + 1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                  state_q,      state_d;
    logic [IDX_W-1:0]        ptr_q,        ptr_d;
    logic [IDX_W-1:0]        grant_q,      grant_d;
    logic [ADDR_WIDTH-1:0]   addr_q,       addr_d;
    logic                    write_q,      write_d;
    logic [DATA_WIDTH-1:0]   wdata_q,      wdata_d;
    logic [NUM_REQ-1:0]      resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_data_q,  resp_data_d;
    logic                    err_q,        err_d;
    logic [CNT_W-1:0]        cnt_q,        cnt_d;

    logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    logic                    any_valid;
    logic                    found;
    logic [IDX_W-1:0]        winner;
    logic [IDX_W:0]          scan_sum;
    logic [IDX_W-1:0]        scan_idx;

    // Scan from the pointer with an explicit modulo wrap so non-power-of-two
    // requester counts never alias through bit truncation.
    always_comb begin
        any_valid = |bus.req_valid;
        found     = 1'b0;
        winner    = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        if ((FETCH_PRIORITY != 0) && bus.req_valid[0]) begin
            found  = 1'b1;
            winner = '0;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, ptr_q} + (IDX_W + 1)'(k);
            if (scan_sum >= C_NUM_REQ) begin
                scan_sum = scan_sum - C_NUM_REQ;
            end
            scan_idx = scan_sum[IDX_W-1:0];
            if (!found && bus.req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    logic timeout_hit;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        cnt_d        = '0;
        timeout_hit  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    addr_d  = addr_arr[winner];
                    write_d = bus.req_write[winner];
                    wdata_d = wdata_arr[winner];
                    grant_d = winner;
                    ptr_d   = (winner == C_LAST_IDX) ? '0 : winner + IDX_W'(1);
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = write_q ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.mem_resp_valid) begin
                    resp_data_d  = bus.mem_resp_data;
                    resp_valid_d = NUM_REQ'(1) << grant_q;
                    state_d      = ST_IDLE;
                end else if (cnt_q == C_CNT_LAST) begin
                    timeout_hit  = 1'b1;
                    resp_data_d  = '0;
                    resp_valid_d = NUM_REQ'(1) << grant_q;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A timeout in the same cycle as a clear leaves the flag set.
        err_d = clr_err ? 1'b0 : err_q;
        if (timeout_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            grant_q      <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.req_ready      = (state_q == ST_IDLE && any_valid && !rst)
                                ? (NUM_REQ'(1) << winner) : '0;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_data      = resp_data_q;
    assign bus.mem_req_valid  = (state_q == ST_REQ);
    assign bus.mem_req_addr   = addr_q;
    assign bus.mem_req_write  = write_q;
    assign bus.mem_req_data   = wdata_q;
    assign bus.mem_resp_ready = (state_q == ST_WAIT);
    assign busy               = (state_q != ST_IDLE);
    assign grant_id           = grant_q;
    assign err_timeout        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_warp_mem_arbiter.sv
// ============================================================================
// Module   : tb_warp_mem_arbiter
// Brief    : Two arbiters (round-robin and fetch-priority) on shared stimulus,
//            checked every cycle against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_warp_mem_arbiter;
    localparam int N  = 9;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    t_valid, t_write;
    logic [N*AW-1:0] t_addr;
    logic [N*DW-1:0] t_wdata;
    logic            t_mready, t_rvalid, t_clr;
    logic [DW-1:0]   t_rdata;

    warp_mem_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0();
    warp_mem_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1();

    assign bus0.req_valid = t_valid;   assign bus1.req_valid = t_valid;
    assign bus0.req_write = t_write;   assign bus1.req_write = t_write;
    assign bus0.req_addr  = t_addr;    assign bus1.req_addr  = t_addr;
    assign bus0.req_wdata = t_wdata;   assign bus1.req_wdata = t_wdata;
    assign bus0.mem_req_ready  = t_mready;  assign bus1.mem_req_ready  = t_mready;
    assign bus0.mem_resp_valid = t_rvalid;  assign bus1.mem_resp_valid = t_rvalid;
    assign bus0.mem_resp_data  = t_rdata;   assign bus1.mem_resp_data  = t_rdata;

    logic       busy0, busy1, err0, err1;
    logic [3:0] grant0, grant1;

    warp_mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .FETCH_PRIORITY(0), .TIMEOUT_CYCLES(TO)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .clr_err(t_clr),
        .busy(busy0), .grant_id(grant0), .err_timeout(err0));

    warp_mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .FETCH_PRIORITY(1), .TIMEOUT_CYCLES(TO)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .clr_err(t_clr),
        .busy(busy1), .grant_id(grant1), .err_timeout(err1));

    logic [N-1:0]  d_ready [2], d_resp [2];
    logic [DW-1:0] d_rdata [2], d_mdata [2];
    logic [AW-1:0] d_maddr [2];
    logic          d_mvalid [2], d_mwrite [2], d_mrready [2], d_busy [2], d_err [2];
    logic [3:0]    d_grant [2];

    assign d_ready[0] = bus0.req_ready;       assign d_ready[1] = bus1.req_ready;
    assign d_resp[0]  = bus0.resp_valid;      assign d_resp[1]  = bus1.resp_valid;
    assign d_rdata[0] = bus0.resp_data;       assign d_rdata[1] = bus1.resp_data;
    assign d_mvalid[0] = bus0.mem_req_valid;  assign d_mvalid[1] = bus1.mem_req_valid;
    assign d_maddr[0] = bus0.mem_req_addr;    assign d_maddr[1] = bus1.mem_req_addr;
    assign d_mwrite[0] = bus0.mem_req_write;  assign d_mwrite[1] = bus1.mem_req_write;
    assign d_mdata[0] = bus0.mem_req_data;    assign d_mdata[1] = bus1.mem_req_data;
    assign d_mrready[0] = bus0.mem_resp_ready; assign d_mrready[1] = bus1.mem_resp_ready;
    assign d_busy[0] = busy0;   assign d_busy[1] = busy1;
    assign d_err[0]  = err0;    assign d_err[1]  = err1;
    assign d_grant[0] = grant0; assign d_grant[1] = grant1;

    // Behavioural model: phase 0 = idle, 1 = request to memory, 2 = awaiting data.
    int            m_phase [2], m_ptr [2], m_grant [2], m_wait [2];
    logic          m_err [2], m_wr [2];
    logic [N-1:0]  m_resp [2];
    logic [DW-1:0] m_rdata [2], m_wd [2];
    logic [AW-1:0] m_addr [2];

    int n_cmp = 0;
    int n_bad = 0;
    int rr_exp [6] = '{2, 5, 8, 2, 5, 8};

    task automatic chk(input string name, input int inst,
                       input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s inst=%0d got=%0h exp=%0h t=%0t", name, inst, got, exp, $time);
        end
    endtask

    function automatic int m_winner(input logic [N-1:0] v, input int ptr, input bit fp);
        if (fp && v[0]) return 0;
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input int i);
        int           w;
        logic [N-1:0] exp_ready;
        if (rst) begin
            chk("rst_req_ready", i, d_ready[i], 0);
            chk("rst_resp_valid", i, d_resp[i], 0);
            chk("rst_resp_data", i, d_rdata[i], 0);
            chk("rst_mem_req_valid", i, d_mvalid[i], 0);
            chk("rst_mem_req_addr", i, d_maddr[i], 0);
            chk("rst_mem_req_data", i, d_mdata[i], 0);
            chk("rst_mem_resp_ready", i, d_mrready[i], 0);
            chk("rst_busy", i, d_busy[i], 0);
            chk("rst_grant", i, d_grant[i], 0);
            chk("rst_err", i, d_err[i], 0);
            m_phase[i] = 0; m_ptr[i] = 0; m_grant[i] = 0; m_wait[i] = 0;
            m_err[i] = 1'b0; m_resp[i] = '0; m_rdata[i] = '0;
            return;
        end
        w = m_winner(t_valid, m_ptr[i], i == 1);
        exp_ready = (m_phase[i] == 0 && w >= 0) ? (N'(1) << w) : '0;
        chk("req_ready", i, d_ready[i], exp_ready);
        chk("busy", i, d_busy[i], m_phase[i] != 0);
        chk("mem_req_valid", i, d_mvalid[i], m_phase[i] == 1);
        chk("mem_resp_ready", i, d_mrready[i], m_phase[i] == 2);
        if (m_phase[i] == 1) begin
            chk("mem_req_addr", i, d_maddr[i], m_addr[i]);
            chk("mem_req_write", i, d_mwrite[i], m_wr[i]);
            chk("mem_req_data", i, d_mdata[i], m_wd[i]);
        end
        chk("resp_valid", i, d_resp[i], m_resp[i]);
        if (m_resp[i] != 0) chk("resp_data", i, d_rdata[i], m_rdata[i]);
        chk("grant_id", i, d_grant[i], m_grant[i]);
        chk("err_timeout", i, d_err[i], m_err[i]);

        m_resp[i] = '0;
        if (t_clr) m_err[i] = 1'b0;
        case (m_phase[i])
            0: if (w >= 0) begin
                m_grant[i] = w;
                m_ptr[i]   = (w + 1) % N;
                m_addr[i]  = t_addr[w*AW +: AW];
                m_wr[i]    = t_write[w];
                m_wd[i]    = t_wdata[w*DW +: DW];
                m_phase[i] = 1;
            end
            1: if (t_mready) begin
                m_phase[i] = m_wr[i] ? 0 : 2;
                m_wait[i]  = 0;
            end
            default: begin
                if (t_rvalid) begin
                    m_resp[i]  = N'(1) << m_grant[i];
                    m_rdata[i] = t_rdata;
                    m_phase[i] = 0;
                end else begin
                    m_wait[i]++;
                    if (m_wait[i] == TO) begin
                        m_err[i]   = 1'b1;
                        m_resp[i]  = N'(1) << m_grant[i];
                        m_rdata[i] = '0;
                        m_phase[i] = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        t_valid = '1; t_write = '0; t_addr = '0; t_wdata = '0;
        t_mready = 1'b0; t_rvalid = 1'b0; t_rdata = '0; t_clr = 1'b0;
        cycle();
        chk("reset_busy", 0, busy0, 0);
        chk("reset_grant", 0, grant0, 0);
        chk("reset_err", 1, err1, 0);
        cycle();
        rst = 1'b0; t_valid = '0;

        // Single read from requester 3.
        t_valid = N'(1) << 3; t_addr[3*AW +: AW] = 32'h10;
        t_mready = 1'b1; t_rvalid = 1'b1; t_rdata = 32'hCAFE0001;
        cycle();
        t_valid = '0;
        chk("rd_mem_req_valid", 0, d_mvalid[0], 1);
        chk("rd_mem_req_addr", 0, d_maddr[0], 32'h10);
        chk("rd_grant", 0, grant0, 3);
        cycle();
        chk("rd_wait_ready", 0, d_mrready[0], 1);
        chk("rd_wait_resp", 0, d_resp[0], 0);
        cycle();
        chk("rd_resp_valid", 0, d_resp[0], 9'h008);
        chk("rd_resp_data", 0, d_rdata[0], 32'hCAFE0001);
        chk("rd_busy_done", 0, busy0, 0);
        cycle();
        chk("rd_resp_pulse_end", 0, d_resp[0], 0);

        // Single write from requester 1.
        t_valid = N'(1) << 1; t_write = N'(1) << 1;
        t_addr[1*AW +: AW] = 32'h20; t_wdata[1*DW +: DW] = 32'h55;
        cycle();
        t_valid = '0;
        chk("wr_mem_req_write", 0, d_mwrite[0], 1);
        chk("wr_mem_req_addr", 0, d_maddr[0], 32'h20);
        chk("wr_mem_req_data", 0, d_mdata[0], 32'h55);
        cycle();
        chk("wr_busy_done", 0, busy0, 0);
        chk("wr_no_resp", 0, d_resp[0], 0);

        // Round-robin 2,5,8 from a fresh pointer.
        rst = 1'b1; cycle(); rst = 1'b0;
        t_write = '1; t_valid = (N'(1) << 2) | (N'(1) << 5) | (N'(1) << 8);
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("rr_grant", 0, grant0, rr_exp[k]);
            cycle();
        end

        // Fetch priority: 0 keeps winning while valid, then 4.
        t_valid = (N'(1) << 0) | (N'(1) << 4);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("fp_grant0", 1, grant1, 0);
            cycle();
        end
        t_valid = N'(1) << 4;
        cycle();
        chk("fp_grant4", 1, grant1, 4);
        t_valid = '0;
        cycle();

        // Memory backpressure then a timeout on requester 6.
        t_valid = N'(1) << 6; t_write = '0; t_addr[6*AW +: AW] = 32'h66AA;
        t_mready = 1'b0; t_rvalid = 1'b0;
        cycle();
        t_valid = '0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 0, d_mvalid[0], 1);
            chk("bp_addr", 0, d_maddr[0], 32'h66AA);
            for (int j = 0; j < N; j++) t_addr[j*AW +: AW] = $urandom;
            cycle();
        end
        t_mready = 1'b1;
        cycle();
        t_mready = 1'b0;
        chk("bp_one_accept", 0, d_mvalid[0], 0);
        for (int k = 1; k < TO; k++) cycle();
        chk("to_still_wait", 0, busy0, 1);
        chk("to_not_yet", 0, err0, 0);
        cycle();
        chk("to_err", 0, err0, 1);
        chk("to_resp_valid", 0, d_resp[0], 9'h040);
        chk("to_resp_data", 0, d_rdata[0], 0);
        repeat (3) cycle();
        chk("to_sticky", 0, err0, 1);
        t_clr = 1'b1; cycle(); t_clr = 1'b0;
        chk("to_cleared", 0, err0, 0);

        // Timeout while clr_err is held: the set must win.
        t_valid = N'(1) << 6; t_mready = 1'b1;
        cycle();
        t_valid = '0;
        cycle();
        t_clr = 1'b1;
        repeat (TO) cycle();
        chk("set_wins", 1, err1, 1);
        t_clr = 1'b0;

        // Reset while waiting on requester 7.
        t_valid = N'(1) << 7;
        cycle();
        t_valid = '0;
        repeat (2) cycle();
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 0, busy0, 0);
        chk("mid_rst_resp_ready", 0, d_mrready[0], 0);
        chk("mid_rst_grant", 0, grant0, 0);
        cycle();
        rst = 1'b0; t_rvalid = 1'b1; t_rdata = 32'h1234;
        repeat (2) cycle();
        chk("mid_rst_no_resp", 0, d_resp[0], 0);
        t_valid = (N'(1) << 3) | (N'(1) << 8); t_write = '1;
        cycle();
        chk("mid_rst_ptr0", 0, grant0, 3);
        t_valid = '0;
        cycle();

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            for (int j = 0; j < N; j++) begin
                t_valid[j] = ($urandom_range(0, 99) < 30);
                t_write[j] = $urandom_range(0, 1);
                t_addr[j*AW +: AW]  = $urandom;
                t_wdata[j*DW +: DW] = $urandom;
            end
            t_mready = ($urandom_range(0, 99) < 70);
            t_rvalid = ($urandom_range(0, 99) < 40);
            t_rdata  = $urandom;
            t_clr    = ($urandom_range(0, 99) < 3);
            rst      = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/warp_mem_arbiter.md
Name: warp_mem_arbiter

Overview:
- Shares the warp engine's single memory request/response port between the instruction fetch unit and the per-lane load/store units.
- Round-robin arbitration over all requesters, with optional fixed priority for fetch (requester 0).
- One transaction in flight at a time; read data is routed back to the requester that issued it.
- Sits between the fetch/lane units and the mem_req_*/mem_resp_* interface of warp_engine.

Parameters:
- NUM_REQ, 9, number of requesters; index 0 = instruction fetch, 1..NUM_REQ-1 = lanes.
- ADDR_WIDTH, 32, memory address width.
- DATA_WIDTH, 32, memory data width.
- FETCH_PRIORITY, 1, 1 = requester 0 always wins when valid; 0 = pure round-robin.
- TIMEOUT_CYCLES, 256, maximum cycles spent in WAIT before a timeout is declared.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot accept; handshake completes on valid&ready.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- resp_valid  out  NUM_REQ  one-cycle read-data pulse to the issuing requester.
- resp_data  out  DATA_WIDTH  read data, shared by all requesters; qualified by resp_valid.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_WIDTH  latched address.
- mem_req_write  out  1  latched write flag.
- mem_req_data  out  DATA_WIDTH  latched write data.
- mem_resp_valid  in  1  memory read data valid.
- mem_resp_ready  out  1  high only in WAIT.
- mem_resp_data  in  DATA_WIDTH  memory read data.
- busy  out  1  state != IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- err_timeout  out  1  sticky timeout flag.
- clr_err  in  1  synchronous clear of err_timeout.

Behaviour:
- Reset (asynchronous, active-high):
  - State returns to IDLE; any in-flight transaction is dropped and no resp_valid is issued for it.
  - RR pointer = 0, grant_id = 0, err_timeout = 0.
  - All outputs are 0, including mem_req_*, resp_valid, resp_data, req_ready and busy.
- States: IDLE, REQ, WAIT.
- IDLE:
  - Winner selection:
    - If FETCH_PRIORITY=1 and req_valid[0]=1, the winner is 0.
    - Otherwise the winner is the first valid index at or after the RR pointer, wrapping modulo NUM_REQ.
  - req_ready = onehot(winner) combinationally; it is 0 when no request is valid.
  - On the handshake edge:
    - Latch addr, write and wdata from the winner.
    - grant_id <= winner; pointer <= (winner+1) mod NUM_REQ.
    - Next state is REQ.
  - A fetch-priority win also advances the pointer.
- REQ:
  - mem_req_valid=1 with the latched fields held stable until mem_req_ready.
  - On handshake: a write goes to IDLE; a read goes to WAIT.
  - req_ready = 0.
- WAIT:
  - mem_resp_ready=1; the timeout counter increments each cycle.
  - On mem_resp_valid:
    - resp_data <= mem_resp_data.
    - resp_valid[grant_id] pulses high for exactly the next cycle.
    - Next state is IDLE, and IDLE arbitrates in that same cycle.
  - If the counter reaches TIMEOUT_CYCLES:
    - err_timeout <= 1.
    - resp_valid[grant_id] pulses with resp_data = 0.
    - Next state is IDLE.
  - The counter clears on leaving WAIT.
- Responses have no backpressure; requesters must accept resp_valid when it pulses.
- mem_resp_valid outside WAIT is ignored.
- Throughput with zero-wait memory (ready=1, response one cycle after accept):
  - Write: 2 cycles per transaction.
  - Read: 3 cycles per transaction.
- Latency: request handshake to mem_req_valid is 1 cycle.
- Requests that drop valid before the handshake are not granted and leave no state.
- clr_err and a timeout in the same cycle: set wins.
- NUM_REQ not a power of two: pointer wrap is explicit mod NUM_REQ, never bit truncation.

Test Plan:
- Single read: req 3 reads 0x10, memory returns 0xCAFE0001 → mem_req_valid 1 cycle after handshake; resp_valid[3] is one cycle wide with resp_data=0xCAFE0001; no other resp_valid bit rises; total 3 cycles.
- Write: req 1 writes 0x55 to 0x20 → mem_req_write=1, mem_req_addr=0x20, mem_req_data=0x55; no resp_valid pulse; busy low after 2 cycles.
- Round-robin: FETCH_PRIORITY=0, reqs 2, 5 and 8 continuously valid from reset → grant order 2,5,8,2,5,8 (pointer wrap 8→0).
- Fetch priority: FETCH_PRIORITY=1, reqs 0 and 4 continuously valid → 0 wins every arbitration; after req 0 drops, 4 is granted next.
- Backpressure and timeout:
  - mem_req_ready held low for 5 cycles → fields stay stable, one accept.
  - Memory never responds, TIMEOUT_CYCLES=256 → err_timeout set at cycle 256 of WAIT; resp_data=0; err_timeout remains set until clr_err.
- Reset mid-operation: rst pulsed while in WAIT → immediate IDLE, outputs 0, no resp_valid; the next request is granted from pointer 0.
